sseg_display_arbiter: RTL
=========================

Name: sseg_display_arbiter

Overview:
Time-shares the single four-digit seven-segment display between four requesters (e.g. button FSM state, timers, debug counters). Round-robin arbitration with a minimum ownership time counted in 1 ms ticks, so a display owner is never preempted faster than a human can read it. Sits between the requesting blocks and the seven-segment controller. Drives that controller's digit-value and digit-enable inputs from the current owner's data.

Parameters:
TICK_CYCLES, 100000, iClk cycles per 1 ms tick (100 MHz board clock)
HOLD_MS, 1000, minimum ms a grant is held while other requesters wait (range 1..65535)

Ports:
iClk  input  1  system clock
iRst  input  1  synchronous active-high reset
iReq  input  4  request per requester, level; bit k = requester k
iData  input  64  digit values; slice [16k+15:16k] = requester k, 4 hex nibbles, [15:12] = leftmost digit
iMask  input  16  digit enables; slice [4k+3:4k] = requester k
oGnt  output  4  one-hot grant, all zero when idle
oData  output  16  owner's digit values, to seven-seg controller
oMask  output  4  owner's digit enables, to seven-seg controller
oBusy  output  1  high while any grant is held
oSwitch  output  1  one-cycle pulse on the edge oGnt takes a new nonzero value

Behaviour:
- Reset: oGnt=0, oData=0, oMask=0, oBusy=0, oSwitch=0, state IDLE, rr pointer=3 (requester 0 has top priority), tick and hold counters 0. Reset asserted mid-grant clears everything on that edge and overrides all other events.
- Round-robin search: start at pointer+1 mod 4 and pick the first set iReq bit. The pointer is updated to the granted index on every grant.
- Tick counter: counts 0..TICK_CYCLES-1 and wraps. The tick pulses on the terminal count. It is cleared on every grant change, so ticks are aligned to grant start.
- Hold counter: 16-bit. Cleared on grant change. Increments on each tick while OWN. Saturates at HOLD_MS. Hold is expired when it equals HOLD_MS, i.e. HOLD_MS*TICK_CYCLES cycles after the grant edge.
- States: IDLE, OWN.
- IDLE: if any iReq bit is set, the next edge grants the round-robin winner and enters OWN. Otherwise stay.
- OWN, owner drops iReq: release on the next edge, regardless of hold. If another request is pending, grant the next round-robin winner on that same edge (no idle gap). Otherwise go to IDLE with oGnt, oData and oMask cleared.
- OWN, hold not expired: keep the grant. Other requests are ignored.
- OWN, hold expired, another requester pending: the next edge grants the round-robin winner that excludes the current owner.
- OWN, hold expired, no other requester: keep the grant with the counter saturated. A later competing request switches on the edge after it appears.
- Simultaneous owner-drop and new request in the same cycle: treat as release with a pending request.
- Output timing: oGnt, oData and oMask are all registered and update on the same edge. On a grant edge, oData and oMask take the new owner's slice sampled before that edge. While OWN, they follow the owner's slice with 1-cycle latency.
- Mask rule: oMask is 0 whenever oGnt is 0.
- oBusy equals |oGnt.
- oSwitch is high for exactly the cycle after a grant edge, including direct owner-to-owner handoff. It is not asserted on release to IDLE.

Test Plan:
All tests use TICK_CYCLES=4 and HOLD_MS=3, so hold is 12 cycles.
- Reset, then iReq=0001, iData[15:0]=0x1234, iMask[3:0]=1111 -> one cycle later: oGnt=0001, oData=0x1234, oMask=1111, oSwitch pulse, oBusy=1.
- Fairness: iReq=1111 held -> grants cycle 0001→0010→0100→1000→0001, each held exactly 12 cycles, with an oSwitch pulse at each change.
- Early release: owner 2 drops iReq at cycle 5 of its hold, requester 0 pending -> next edge oGnt=0001, no IDLE cycle. Owner alone drops -> oGnt=0, oMask=0, oBusy=0, no oSwitch.
- Lone owner: iReq=0100 for 40 cycles -> oGnt stays 0100. Assert iReq[1] at cycle 40 -> oGnt=0010 on the next edge.
- Data tracking: owner changes iData slice 0x1234→0xBEEF -> oData shows 0xBEEF one cycle later. Non-owner slice changes never appear on oData.
- Reset mid-hold: assert iRst while oGnt=1000 -> all outputs 0 next edge. After release with iReq=1111, the first grant is 0001.

Source files
------------

// File: rtl/sseg_display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_display_arbiter_if
//  Description : Bundle between the display requesters and the arbiter.
//                master = requester side (drives iReq/iData/iMask),
//                slave  = arbiter side (drives grant and display outputs).
//  Signals     : iReq[3:0]    level request, bit k = requester k
//                iData[63:0]  digit values, [16k+15:16k] = requester k
//                iMask[15:0]  digit enables, [4k+3:4k] = requester k
//                oGnt[3:0]    one-hot grant
//                oData[15:0]  owner's digit values
//                oMask[3:0]   owner's digit enables
//                oBusy        any grant held
//                oSwitch      one-cycle pulse after a new grant
//  Revision    : 1.0 - initial release
// ============================================================================
interface sseg_display_arbiter_if;
    logic [3:0]  iReq;
    logic [63:0] iData;
    logic [15:0] iMask;
    logic [3:0]  oGnt;
    logic [15:0] oData;
    logic [3:0]  oMask;
    logic        oBusy;
    logic        oSwitch;

    modport master (
        output iReq, iData, iMask,
        input  oGnt, oData, oMask, oBusy, oSwitch
    );

    modport slave (
        input  iReq, iData, iMask,
        output oGnt, oData, oMask, oBusy, oSwitch
    );
endinterface
`default_nettype wire

// File: rtl/sseg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_display_arbiter
//  Description : Round-robin time-sharing of one 4-digit seven-segment display
//                between four requesters, with a minimum ownership time counted
//                in 1 ms ticks so an owner is not preempted too quickly.
//  Ports       : iClk  - system clock
//                iRst  - synchronous active-high reset
//                bus   - sseg_display_arbiter_if.slave (requests, data, grant)
//  Parameters  : TICK_CYCLES - iClk cycles per 1 ms tick
//                HOLD_MS     - minimum ms a grant is held under contention
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_display_arbiter #(
    parameter int TICK_CYCLES = 100000,
    parameter int HOLD_MS     = 1000
) (
    input  wire logic              iClk,
    input  wire logic              iRst,
    sseg_display_arbiter_if.slave  bus
);

    localparam int              c_TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_CYCLES - 1);
    localparam logic [15:0]     c_HOLD      = 16'(HOLD_MS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_ptr;      // last granted index; equals owner while OWN
    logic [c_TW-1:0] r_tick;
    logic [15:0]     r_hold;
    logic [3:0]      r_gnt;
    logic [15:0]     r_data;
    logic [3:0]      r_mask;
    logic            r_switch;

    logic            w_tick;
    logic            w_expired;
    logic            w_grant;
    logic            w_release;
    logic [3:0]      w_cand;
    logic [3:0]      w_others;
    logic [1:0]      w_win;
    logic [1:0]      w_idx;
    logic            w_found;

    assign w_tick   = (r_state == ST_OWN) && (r_tick == c_TICK_LAST);
    // Expiry looks ahead by the tick that is about to saturate the counter, so
    // the switch edge lands exactly HOLD_MS*TICK_CYCLES cycles after the grant.
    assign w_expired = (r_hold == c_HOLD) || (w_tick && (r_hold == c_HOLD - 16'd1));
    assign w_others  = bus.iReq & ~r_gnt;

    // Next-state and grant decision.
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_release = 1'b0;
        w_cand    = bus.iReq;
        case (r_state)
            ST_IDLE: begin
                if (|bus.iReq) begin
                    w_grant = 1'b1;
                    w_next  = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!bus.iReq[r_ptr]) begin
                    // Owner dropped: hand off directly if anyone else waits.
                    if (|bus.iReq) begin
                        w_grant = 1'b1;
                    end else begin
                        w_release = 1'b1;
                        w_next    = ST_IDLE;
                    end
                end else if (w_expired && (|w_others)) begin
                    w_cand  = w_others;
                    w_grant = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Round-robin search from r_ptr+1; the owner itself is checked last.
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && w_cand[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_ptr    <= 2'd3;
            r_tick   <= '0;
            r_hold   <= '0;
            r_gnt    <= '0;
            r_data   <= '0;
            r_mask   <= '0;
            r_switch <= 1'b0;
        end else begin
            r_switch <= w_grant;
            if (w_grant) begin
                r_ptr  <= w_win;
                r_gnt  <= 4'b0001 << w_win;
                r_data <= bus.iData[{w_win, 4'b0000} +: 16];
                r_mask <= bus.iMask[{w_win, 2'b00} +: 4];
                r_tick <= '0;
                r_hold <= '0;
            end else if (w_release) begin
                r_gnt  <= '0;
                r_data <= '0;
                r_mask <= '0;
                r_tick <= '0;
                r_hold <= '0;
            end else if (r_state == ST_OWN) begin
                r_data <= bus.iData[{r_ptr, 4'b0000} +: 16];
                r_mask <= bus.iMask[{r_ptr, 2'b00} +: 4];
                r_tick <= w_tick ? '0 : r_tick + 1'b1;
                if (w_tick && (r_hold != c_HOLD)) begin
                    r_hold <= r_hold + 16'd1;
                end
            end
        end
    end

    assign bus.oGnt    = r_gnt;
    assign bus.oData   = r_data;
    assign bus.oMask   = r_mask;
    assign bus.oBusy   = |r_gnt;
    assign bus.oSwitch = r_switch;

endmodule
`default_nettype wire
